uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Consumes the byte stream produced by the UART receive stage and assembles fixed 5-byte command frames.
- Frame layout: 0x55 header, cmd, arg_hi, arg_lo, checksum.
- A frame with a valid checksum produces a one-cycle cmd_valid pulse carrying cmd_code and cmd_arg to the instrument control logic.
- Malformed or stalled frames are discarded and flagged on frame_err.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 9600, serial baud rate in bit/s.
- GAP_BYTES, 3, inter-byte timeout measured in byte times (10 bits each).
- TIMEOUT_CYC (localparam), CLK_FREQ/UART_BPS*10*GAP_BYTES, timeout length in clock cycles.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  reset, synchronous, active-low.
- rx_done  input  1  one-cycle strobe: rx_data holds a newly received byte.
- rx_data  input  8  received byte, valid only while rx_done=1.
- cmd_valid  output  1  one-cycle pulse: a good frame was decoded.
- cmd_code  output  8  command byte of the last good frame.
- cmd_arg  output  16  {arg_hi, arg_lo} of the last good frame.
- frame_err  output  1  one-cycle pulse: bad checksum or timeout.
- err_cnt  output  8  present only when UART_CMD_ERRCNT_EN is defined.

Behaviour:
- One clock: sys_clk. Reset sys_rst_n is synchronous and active-low, sampled only on the sys_clk rising edge.
- Reset values:
  - state=IDLE.
  - cmd_valid=0, frame_err=0.
  - cmd_code=0x00, cmd_arg=0x0000.
  - gap counter=0, checksum accumulator=0.
  - err_cnt=0 when compiled in.
- Reset mid-frame abandons the frame silently: no frame_err pulse, no err_cnt increment.
- States and transitions (advance only on cycles with rx_done=1):
  - IDLE: byte 0x55 -> CMD, accumulator cleared; any other byte ignored, no error.
  - CMD: store cmd, acc=byte -> ARG_H.
  - ARG_H: store arg_hi, acc+=byte -> ARG_L.
  - ARG_L: store arg_lo, acc+=byte -> CHK.
  - CHK: compare byte against acc, then -> IDLE in both cases.
    - Match: cmd_valid=1 for exactly one cycle, the cycle after the checksum strobe. cmd_code and cmd_arg update in that same cycle.
    - Mismatch: frame_err=1 for one cycle with the same timing; cmd_code and cmd_arg keep their previous values.
- Checksum arithmetic: 8-bit sum of cmd+arg_hi+arg_lo, modulo 256; carries discarded.
- Header value 0x55 appearing in the CMD/ARG/CHK positions is ordinary data, never a resync.
- cmd_code and cmd_arg hold their values until the next good frame.
- Gap timeout:
  - Counter runs only while state!=IDLE and clears on every rx_done.
  - After TIMEOUT_CYC consecutive cycles without rx_done: state -> IDLE, frame_err pulses one cycle, no cmd_valid.
  - If rx_done arrives in the same cycle the counter reaches TIMEOUT_CYC-1, the byte wins and no timeout occurs.
  - Counter is held at 0 in IDLE.
- cmd_valid and frame_err are never asserted in the same cycle.
- Latency from checksum-byte strobe to cmd_valid: exactly 1 cycle.
- Back-to-back frames are allowed: a header byte on the strobe right after CHK is accepted.

Optional Feature:
- Macro: UART_CMD_ERRCNT_EN.
- Defined: port err_cnt[7:0] exists. It increments on every frame_err pulse, saturates at 0xFF, and clears only on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum (IDLE, CMD, ARG_H, ARG_L, CHK), 3-bit encoding;
  - HDR_BYTE=8'h55;
  - FRAME_LEN=5.
- One sub-module is natural: uart_gap_timer.
  - Inputs: clk, rst_n, enable, kick.
  - Output: one-cycle expired pulse.
  - Parameter: TIMEOUT_CYC; counter width $clog2(TIMEOUT_CYC+1).

Test Plan:
- Good frame: bytes 55 01 12 34 47 on rx_done strobes -> cmd_valid one cycle after the 0x47 strobe; cmd_code=0x01, cmd_arg=0x1234; frame_err stays 0.
- Bad checksum: 55 01 12 34 48 -> frame_err pulses once; cmd_valid=0; cmd_code and cmd_arg keep their previous values; err_cnt=1 (macro on).
- Junk then frame: 00 FF 55 A0 55 55 4A -> junk ignored; cmd_code=0xA0, cmd_arg=0x5555, cmd_valid=1 (A0+55+55=0x14A -> 0x4A).
- Timeout: 55 01, then silence for TIMEOUT_CYC cycles -> frame_err exactly TIMEOUT_CYC cycles after the 0x01 strobe; state IDLE; a following 55 02 00 00 02 gives cmd_code=0x02.
- Boundary: next byte strobed on cycle TIMEOUT_CYC-1 after the previous one -> no frame_err and the frame completes. Reset asserted after 55 01 12, then 34 47 sent -> no cmd_valid, no frame_err.
- Saturation (macro on): 300 bad-checksum frames -> err_cnt=0xFF and holds there.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame parser.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      ARG_H = 3'd2,
      ARG_L = 3'd3,
      CHK   = 3'd4
   } state_t;

   localparam logic [7:0] HDR_BYTE  = 8'h55;
   localparam int         FRAME_LEN = 5;

   // Frame checksum is a plain 8-bit sum; carries fall off the top.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/uart_cmd_parser_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, pulses expired once the gap is too long.
module uart_gap_timer #(
   parameter int TIMEOUT_CYC = 156240
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic kick,
   output logic expired
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A kick on the final count wins over expiry.
   always_comb begin
      expired = 1'b0;
      cnt_d   = cnt_q;
      if (!enable || kick) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         expired = 1'b1;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte UART command frames (55 cmd arg_hi arg_lo sum) into cmd_valid pulses.
// Optional error counter port err_cnt is compiled in with UART_CMD_ERRCNT_EN.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 9600,
   parameter int GAP_BYTES = 3
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        rx_done,
   input  logic [7:0]  rx_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic [15:0] cmd_arg,
   output logic        frame_err
`ifdef UART_CMD_ERRCNT_EN
   ,
   output logic [7:0]  err_cnt
`endif
);

   localparam int TIMEOUT_CYC = CLK_FREQ / UART_BPS * 10 * GAP_BYTES;

   state_t      state_q, state_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  arg_hi_q, arg_hi_d;
   logic [7:0]  arg_lo_q, arg_lo_d;
   logic [7:0]  acc_q, acc_d;
   logic [7:0]  cmd_code_q, cmd_code_d;
   logic [15:0] cmd_arg_q, cmd_arg_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        gap_expired;

   uart_gap_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_gap_timer (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .enable (state_q != IDLE),
      .kick   (rx_done),
      .expired(gap_expired)
   );

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      arg_hi_d    = arg_hi_q;
      arg_lo_d    = arg_lo_q;
      acc_d       = acc_q;
      cmd_code_d  = cmd_code_q;
      cmd_arg_d   = cmd_arg_q;
      cmd_valid_d = 1'b0;
      frame_err_d = 1'b0;
      if (rx_done) begin
         unique case (state_q)
            IDLE: begin
               if (rx_data == HDR_BYTE) begin
                  state_d = CMD;
                  acc_d   = '0;
               end
            end
            CMD: begin
               cmd_d   = rx_data;
               acc_d   = rx_data;
               state_d = ARG_H;
            end
            ARG_H: begin
               arg_hi_d = rx_data;
               acc_d    = csum_add(acc_q, rx_data);
               state_d  = ARG_L;
            end
            ARG_L: begin
               arg_lo_d = rx_data;
               acc_d    = csum_add(acc_q, rx_data);
               state_d  = CHK;
            end
            CHK: begin
               state_d = IDLE;
               if (rx_data == acc_q) begin
                  cmd_valid_d = 1'b1;
                  cmd_code_d  = cmd_q;
                  cmd_arg_d   = {arg_hi_q, arg_lo_q};
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (gap_expired) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         cmd_q       <= '0;
         arg_hi_q    <= '0;
         arg_lo_q    <= '0;
         acc_q       <= '0;
         cmd_code_q  <= '0;
         cmd_arg_q   <= '0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         arg_hi_q    <= arg_hi_d;
         arg_lo_q    <= arg_lo_d;
         acc_q       <= acc_d;
         cmd_code_q  <= cmd_code_d;
         cmd_arg_q   <= cmd_arg_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_arg   = cmd_arg_q;
   assign frame_err = frame_err_q;

`ifdef UART_CMD_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Counts in step with the frame_err register so both change on the same edge.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) err_cnt_q <= '0;
      else            err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed, table-driven bench for uart_cmd_parser; honours UART_CMD_ERRCNT_EN when defined.
module tb_uart_cmd_parser;

   localparam int CLK_FREQ  = 400;
   localparam int UART_BPS  = 100;
   localparam int GAP_BYTES = 1;
   localparam int T         = 40;   // 400/100*10*1

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        rx_done   = 1'b0;
   logic [7:0]  rx_data   = 8'h00;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic [15:0] cmd_arg;
   logic        frame_err;
`ifdef UART_CMD_ERRCNT_EN
   logic [7:0]  err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   uart_cmd_parser #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS),
      .GAP_BYTES(GAP_BYTES)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .rx_done  (rx_done),
      .rx_data  (rx_data),
      .cmd_valid(cmd_valid),
      .cmd_code (cmd_code),
      .cmd_arg  (cmd_arg),
      .frame_err(frame_err)
`ifdef UART_CMD_ERRCNT_EN
      ,
      .err_cnt  (err_cnt)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [7:0]  data;
      logic        exp_v;
      logic        exp_e;
      logic [7:0]  exp_code;
      logic [15:0] exp_arg;
      logic [7:0]  exp_ecnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [7:0] d, input logic v, input logic e,
                      input logic [7:0] c, input logic [15:0] a, input logic [7:0] n);
      vec_t t;
      t.data = d; t.exp_v = v; t.exp_e = e; t.exp_code = c; t.exp_arg = a; t.exp_ecnt = n;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic v, input logic e,
                             input logic [7:0] c, input logic [15:0] a, input logic [7:0] n);
      chk({tag, "_valid"}, 32'(cmd_valid), 32'(v));
      chk({tag, "_err"},   32'(frame_err), 32'(e));
      chk({tag, "_code"},  32'(cmd_code),  32'(c));
      chk({tag, "_arg"},   32'(cmd_arg),   32'(a));
`ifdef UART_CMD_ERRCNT_EN
      chk({tag, "_ecnt"},  32'(err_cnt),   32'(n));
`else
      if (n != n) $display("unreachable");
`endif
   endtask

   // Strobe one byte; returns at the falling edge right after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge sys_clk);
      rx_done = 1'b1;
      rx_data = b;
      @(negedge sys_clk);
      rx_done = 1'b0;
      rx_data = 8'hA5;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] burst [10];
      logic [7:0] bnd   [4];
      int         seen;
      int         pulses;
      logic       anyv;
      logic       anye;

      burst = '{8'h55, 8'h03, 8'h00, 8'h01, 8'h04, 8'h55, 8'h04, 8'h00, 8'h00, 8'h04};
      bnd   = '{8'h01, 8'h12, 8'h34, 8'h47};

      // good frame
      add(8'h55, 0, 0, 8'h00, 16'h0000, 0);
      add(8'h01, 0, 0, 8'h00, 16'h0000, 0);
      add(8'h12, 0, 0, 8'h00, 16'h0000, 0);
      add(8'h34, 0, 0, 8'h00, 16'h0000, 0);
      add(8'h47, 1, 0, 8'h01, 16'h1234, 0);
      // bad checksum
      add(8'h55, 0, 0, 8'h01, 16'h1234, 0);
      add(8'h01, 0, 0, 8'h01, 16'h1234, 0);
      add(8'h12, 0, 0, 8'h01, 16'h1234, 0);
      add(8'h34, 0, 0, 8'h01, 16'h1234, 0);
      add(8'h48, 0, 1, 8'h01, 16'h1234, 1);
      // junk, then a frame with 0x55 as data
      add(8'h00, 0, 0, 8'h01, 16'h1234, 1);
      add(8'hFF, 0, 0, 8'h01, 16'h1234, 1);
      add(8'h55, 0, 0, 8'h01, 16'h1234, 1);
      add(8'hA0, 0, 0, 8'h01, 16'h1234, 1);
      add(8'h55, 0, 0, 8'h01, 16'h1234, 1);
      add(8'h55, 0, 0, 8'h01, 16'h1234, 1);
      add(8'h4A, 1, 0, 8'hA0, 16'h5555, 1);
      // checksum wraps: FF+FF+FF = 0x2FD
      add(8'h55, 0, 0, 8'hA0, 16'h5555, 1);
      add(8'hFF, 0, 0, 8'hA0, 16'h5555, 1);
      add(8'hFF, 0, 0, 8'hA0, 16'h5555, 1);
      add(8'hFF, 0, 0, 8'hA0, 16'h5555, 1);
      add(8'hFD, 1, 0, 8'hFF, 16'hFFFF, 1);

      // reset state
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check_outs("reset", 0, 0, 8'h00, 16'h0000, 0);
      sys_rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         send_byte(vecs[i].data);
         check_outs($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_e,
                    vecs[i].exp_code, vecs[i].exp_arg, vecs[i].exp_ecnt);
         @(negedge sys_clk);
         chk($sformatf("vec%0d_drop", i), {30'd0, cmd_valid, frame_err}, 32'd0);
      end

      // back-to-back frames, strobes on consecutive cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         if (i == 5) check_outs("b2b_first", 1, 0, 8'h03, 16'h0001, 1);
         rx_done = 1'b1;
         rx_data = burst[i];
      end
      @(negedge sys_clk);
      rx_done = 1'b0;
      check_outs("b2b_second", 1, 0, 8'h04, 16'h0000, 1);

      // gap timeout after 55 01
      send_byte(8'h55);
      send_byte(8'h01);
      seen = -1; pulses = 0; anyv = 1'b0;
      for (int k = 1; k <= T + 5; k++) begin
         @(negedge sys_clk);
         anyv = anyv | cmd_valid;
         if (frame_err) begin
            pulses++;
            if (seen < 0) seen = k;
         end
      end
      chk("timeout_cycle", 32'(seen), 32'(T));
      chk("timeout_pulses", 32'(pulses), 32'd1);
      chk("timeout_novalid", 32'(anyv), 32'd0);
`ifdef UART_CMD_ERRCNT_EN
      chk("timeout_ecnt", 32'(err_cnt), 32'd2);
`endif
      send_byte(8'h55);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h02);
      check_outs("after_timeout", 1, 0, 8'h02, 16'h0000, 2);

      // each byte lands exactly on the last tolerated cycle
      anye = 1'b0;
      send_byte(8'h55);
      for (int i = 0; i < 4; i++) begin
         repeat (T - 2) begin
            @(negedge sys_clk);
            anye = anye | frame_err;
         end
         send_byte(bnd[i]);
         if (i < 3) anye = anye | frame_err;
      end
      check_outs("boundary", 1, 0, 8'h01, 16'h1234, 2);
      chk("boundary_noerr", 32'(anye), 32'd0);

      // reset mid-frame abandons silently
      send_byte(8'h55);
      send_byte(8'h01);
      send_byte(8'h12);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      check_outs("midrst", 0, 0, 8'h00, 16'h0000, 0);
      send_byte(8'h34);
      check_outs("midrst_34", 0, 0, 8'h00, 16'h0000, 0);
      send_byte(8'h47);
      check_outs("midrst_47", 0, 0, 8'h00, 16'h0000, 0);
      anye = 1'b0; anyv = 1'b0;
      repeat (T + 5) begin
         @(negedge sys_clk);
         anye = anye | frame_err;
         anyv = anyv | cmd_valid;
      end
      chk("midrst_quiet", {30'd0, anyv, anye}, 32'd0);

`ifdef UART_CMD_ERRCNT_EN
      // error counter saturation
      for (int n = 0; n < 300; n++) begin
         send_byte(8'h55);
         send_byte(8'h01);
         send_byte(8'h12);
         send_byte(8'h34);
         send_byte(8'h48);
         if (n == 253) chk("ecnt_254", 32'(err_cnt), 32'd254);
         if (n == 254) chk("ecnt_255", 32'(err_cnt), 32'hFF);
      end
      chk("ecnt_sat", 32'(err_cnt), 32'hFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
